// File: rtl/y86_pkg.sv
// Y86-64 definitions shared by fetch and decode: instruction codes, register
// sentinel, length width, fetch sequencer states and the length-decode record.
package y86_pkg;

   localparam int ILEN_W = 4;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [2:0] {
      S_OP,
      S_REG,
      S_CONST,
      S_HOLD,
      S_HALT,
      S_ERR
   } fetch_state_t;

   typedef struct packed {
      logic              need_regids;
      logic              need_valc;
      logic [ILEN_W-1:0] len;
      logic              invalid;
   } ilen_info_t;

   // Opcode byte, optional regid byte, optional 8-byte constant.
   function automatic logic [ILEN_W-1:0] instr_len(input logic need_regids,
                                                   input logic need_valc);
      logic [ILEN_W-1:0] len;
      len = ILEN_W'(1);
      if (need_regids)
         len = len + ILEN_W'(1);
      if (need_valc)
         len = len + ILEN_W'(8);
      return len;
   endfunction

endpackage

// File: rtl/y86_ilen.sv
// Combinational instruction-shape decode: which optional fields follow the
// opcode byte, the resulting length, and whether the icode is undefined.
import y86_pkg::*;

module y86_ilen (
   input  logic [3:0] icode,
   output ilen_info_t info
);

   always_comb begin
      info = '0;
      case (icode)
         I_HALT, I_NOP, I_RET: begin
            info.need_regids = 1'b0;
         end
         I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
            info.need_regids = 1'b1;
         end
         I_JXX, I_CALL: begin
            info.need_valc = 1'b1;
         end
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
            info.need_regids = 1'b1;
            info.need_valc   = 1'b1;
         end
         default: begin
            info.invalid = 1'b1;
         end
      endcase
      info.len = instr_len(info.need_regids, info.need_valc);
   end

endmodule

// File: rtl/y86_fetch_seq.sv
// Y86-64 byte-serial fetch stage: walks the instruction bytes at pc, assembles
// the decoded fields and holds them until decode accepts, then advances pc.
import y86_pkg::*;

module y86_fetch_seq #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [63:0] imem_addr_o,
   input  logic [7:0]  imem_rdata_i,
   input  logic        imem_valid_i,
   input  logic        issue_ready_i,
   input  logic        pc_load_i,
   input  logic [63:0] pc_next_i,
   output logic        instr_valid_o,
   output logic [3:0]  icode_o,
   output logic [3:0]  ifun_o,
   output logic [3:0]  rA_o,
   output logic [3:0]  rB_o,
   output logic [63:0] valC_o,
   output logic [63:0] valP_o,
   output logic [63:0] pc_o,
   output logic        halt_o,
   output logic        instr_err_o
);

   fetch_state_t state_reg, state_next;

   logic [63:0] pc_reg;
   logic [2:0]  idx_reg;
   logic [3:0]  icode_reg, ifun_reg;
   logic [3:0]  ra_reg, rb_reg;
   logic [63:0] valc_reg, valc_next;
   logic [63:0] valp_reg;

   logic        req;
   logic        xfer;
   logic        latch_op, latch_reg, latch_const, issue;
   logic [3:0]  dec_icode;
   ilen_info_t  info;
   logic [63:0] const_off;
   logic [7:0]  lane_we;

   // While the opcode byte is arriving, decode it directly off the bus.
   assign dec_icode = (state_reg == S_OP) ? imem_rdata_i[7:4] : icode_reg;

   y86_ilen u_ilen (
      .icode (dec_icode),
      .info  (info)
   );

   assign const_off = info.need_regids ? 64'd2 : 64'd1;
   assign xfer      = imem_req_o & imem_valid_i;

   always_comb begin
      state_next    = state_reg;
      req           = 1'b0;
      imem_addr_o   = pc_reg;
      instr_valid_o = 1'b0;
      latch_op      = 1'b0;
      latch_reg     = 1'b0;
      latch_const   = 1'b0;
      issue         = 1'b0;
      case (state_reg)
         S_OP: begin
            req = 1'b1;
            if (xfer) begin
               latch_op = 1'b1;
               if (info.invalid)
                  state_next = S_ERR;
               else if (info.len == ILEN_W'(1))
                  state_next = S_HOLD;
               else if (info.need_regids)
                  state_next = S_REG;
               else
                  state_next = S_CONST;
            end
         end
         S_REG: begin
            req         = 1'b1;
            imem_addr_o = pc_reg + 64'd1;
            if (xfer) begin
               latch_reg  = 1'b1;
               state_next = info.need_valc ? S_CONST : S_HOLD;
            end
         end
         S_CONST: begin
            req         = 1'b1;
            imem_addr_o = pc_reg + const_off + {61'd0, idx_reg};
            if (xfer) begin
               latch_const = 1'b1;
               if (idx_reg == 3'd7)
                  state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            instr_valid_o = 1'b1;
            if (issue_ready_i) begin
               issue      = 1'b1;
               state_next = (icode_reg == I_HALT) ? S_HALT : S_OP;
            end
         end
         S_HALT, S_ERR: begin
            state_next = state_reg;
         end
         default: begin
            state_next = S_OP;
         end
      endcase
   end

   // Reset must silence the request even though the reset state is S_OP.
   assign imem_req_o = req & ~rst_i;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign lane_we[gi] = latch_const && (idx_reg == 3'(gi));
         assign valc_next[8*gi +: 8] = issue       ? 8'h00 :
                                       lane_we[gi] ? imem_rdata_i :
                                                     valc_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= S_OP;
         pc_reg    <= RESET_PC;
         idx_reg   <= 3'd0;
         icode_reg <= 4'h0;
         ifun_reg  <= 4'h0;
         ra_reg    <= REG_NONE;
         rb_reg    <= REG_NONE;
         valc_reg  <= 64'h0;
         valp_reg  <= 64'h0;
      end else begin
         state_reg <= state_next;
         valc_reg  <= valc_next;
         if (latch_op) begin
            icode_reg <= imem_rdata_i[7:4];
            ifun_reg  <= imem_rdata_i[3:0];
            valp_reg  <= pc_reg + 64'(info.len);
         end
         if (latch_reg) begin
            ra_reg <= imem_rdata_i[7:4];
            rb_reg <= imem_rdata_i[3:0];
         end
         // Index wraps back to 0 after the eighth constant byte.
         if (latch_const)
            idx_reg <= idx_reg + 3'd1;
         if (issue) begin
            pc_reg    <= pc_load_i ? pc_next_i : valp_reg;
            idx_reg   <= 3'd0;
            icode_reg <= 4'h0;
            ifun_reg  <= 4'h0;
            ra_reg    <= REG_NONE;
            rb_reg    <= REG_NONE;
            valp_reg  <= 64'h0;
         end
      end
   end

   assign icode_o     = icode_reg;
   assign ifun_o      = ifun_reg;
   assign rA_o        = ra_reg;
   assign rB_o        = rb_reg;
   assign valC_o      = valc_reg;
   assign valP_o      = valp_reg;
   assign pc_o        = pc_reg;
   assign halt_o      = (state_reg == S_HALT);
   assign instr_err_o = (state_reg == S_ERR);

endmodule
